// File: rtl/lcd_show_num_pkg.sv
// Shared constants and FSM encoding for the decimal field sequencer in front of lcd_show_char.
// Font advance widths and the ASCII offset match the lcd_show_char size constants.
package lcd_show_num_pkg;

  localparam int FONT_ASCII_OFFSET = 32;
  localparam int FONT12_ADV        = 6;
  localparam int FONT16_ADV        = 8;
  localparam int CONV_CYCLES       = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_LOAD = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_NEXT = 3'd5,
    S_FIN  = 3'd6
  } state_t;

endpackage

// File: rtl/lcd_show_num_bin16_to_bcd5.sv
// Sequential double-dabble: a start pulse loads bin, and after 16 add-3/shift steps
// bcd holds five decimal nibbles with valid pulsed for one cycle.
module bin16_to_bcd5
  import lcd_show_num_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        valid
);

  logic [15:0] bin_q;
  logic [3:0]  cnt;
  logic        run;
  logic [19:0] adj;

  always_comb begin
    adj = bcd;
    for (int n = 0; n < 5; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_q <= '0;
      bcd   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      valid <= 1'b0;
    end else if (start) begin
      bin_q <= bin;
      bcd   <= '0;
      cnt   <= '0;
      run   <= 1'b1;
      valid <= 1'b0;
    end else if (run) begin
      // adjusted BCD and the remaining binary shift together as one 36-bit register
      {bcd, bin_q} <= {adj[18:0], bin_q, 1'b0};
      cnt          <= cnt + 4'd1;
      if (cnt == 4'(CONV_CYCLES - 1)) begin
        run   <= 1'b0;
        valid <= 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_show_num.sv
// Displays an unsigned 16-bit value as a fixed-width decimal field by issuing one
// lcd_show_char request per digit, most significant first, advancing x per glyph.
module lcd_show_num
  import lcd_show_num_pkg::*;
#(
  parameter int DIGITS       = 5,
  parameter int CHAR_W0      = FONT12_ADV,
  parameter int CHAR_W1      = FONT16_ADV,
  parameter int ASCII_OFFSET = FONT_ASCII_OFFSET
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [15:0] num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        en_size_in,
  input  logic        blank_lead,
  input  logic        show_char_done,
  output logic        show_char_flag,
  output logic [6:0]  ascii_num,
  output logic [8:0]  char_x,
  output logic [8:0]  char_y,
  output logic        en_size,
  output logic        busy,
  output logic        done,
  output state_t      fsm_state
);

  localparam logic [6:0] ZERO_GLYPH = 7'(48 - ASCII_OFFSET);
  localparam logic [8:0] ADV0       = 9'(CHAR_W0);
  localparam logic [8:0] ADV1       = 9'(CHAR_W1);

  // Handshake: show_char_flag pulses for one cycle in REQ; ascii_num/char_x/char_y/en_size
  // are stable from REQ until show_char_done is seen in WAIT. done is ignored elsewhere.
  state_t      state, state_nxt;
  logic [19:0] bcd;
  logic        conv_valid;
  logic        accept;
  logic [2:0]  idx;
  logic        blank_q;
  logic        leading;
  logic [3:0]  cur_digit;
  logic        blank_now;

  assign accept    = (state == S_IDLE) && start;
  assign cur_digit = bcd[{idx, 2'b00} +: 4];
  assign blank_now = blank_q && leading && (idx != 3'd0) && (cur_digit == 4'd0);
  assign fsm_state = state;

  bin16_to_bcd5 u_bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (accept),
    .bin       (num),
    .bcd       (bcd),
    .valid     (conv_valid)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CONV;
      S_CONV: if (conv_valid) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: if (show_char_done) state_nxt = S_NEXT;
      S_NEXT: state_nxt = (idx == 3'd0) ? S_FIN : S_LOAD;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    show_char_flag = 1'b0;
    done           = 1'b0;
    busy           = 1'b0;
    if (state == S_REQ) show_char_flag = 1'b1;
    if (state == S_FIN) done = 1'b1;
    if (state != S_IDLE) busy = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ascii_num <= '0;
      char_x    <= '0;
      char_y    <= '0;
      en_size   <= 1'b0;
      idx       <= '0;
      blank_q   <= 1'b0;
      leading   <= 1'b0;
    end else begin
      if (accept) begin
        char_x  <= start_x;
        char_y  <= start_y;
        en_size <= en_size_in;
        blank_q <= blank_lead;
        idx     <= 3'(DIGITS - 1);
        leading <= 1'b1;
      end
      if (state == S_LOAD) begin
        ascii_num <= blank_now ? 7'd0 : ZERO_GLYPH + {3'b000, cur_digit};
        if (cur_digit != 4'd0) leading <= 1'b0;
      end
      if (state == S_NEXT) begin
        // 9-bit add wraps modulo 512; no clipping at the panel edge
        char_x <= char_x + (en_size ? ADV1 : ADV0);
        if (idx != 3'd0) idx <= idx - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_show_num.sv
// Bench for lcd_show_num: an inline lcd_show_char model answers each request after a
// random delay, and a decimal reference model supplies the expected glyphs and positions.
module tb_lcd_show_num;
  import lcd_show_num_pkg::*;

  localparam int DIGITS = 5;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [15:0] num_in;
  logic [8:0]  start_x;
  logic [8:0]  start_y;
  logic        en_size_in;
  logic        blank_lead;
  logic        show_char_done;
  logic        show_char_flag;
  logic [6:0]  ascii_num;
  logic [8:0]  char_x;
  logic [8:0]  char_y;
  logic        en_size;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  int vectors;
  int miscompares;

  logic [6:0] exp_ascii_q[$];
  logic [8:0] exp_x_q[$];

  lcd_show_num dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .start          (start),
    .num            (num_in),
    .start_x        (start_x),
    .start_y        (start_y),
    .en_size_in     (en_size_in),
    .blank_lead     (blank_lead),
    .show_char_done (show_char_done),
    .show_char_flag (show_char_flag),
    .ascii_num      (ascii_num),
    .char_x         (char_x),
    .char_y         (char_y),
    .en_size        (en_size),
    .busy           (busy),
    .done           (done),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: decimal digits by division, leading-zero rule over the field
  task automatic build_expected(input logic [15:0] n, input logic [8:0] x0,
                                input logic size, input logic blank);
    int d[5];
    int p;
    int w;
    int k;
    bit lead;
    exp_ascii_q.delete();
    exp_x_q.delete();
    p = 1;
    for (int j = 0; j < 5; j++) begin
      d[j] = (int'(n) / p) % 10;
      p = p * 10;
    end
    w = size ? 8 : 6;
    k = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = 1'b1;
      for (int j = i; j < DIGITS; j++) if (d[j] != 0) lead = 1'b0;
      if (blank && i > 0 && lead) exp_ascii_q.push_back(7'd0);
      else exp_ascii_q.push_back(7'(16 + d[i]));
      exp_x_q.push_back(9'((int'(x0) + k * w) % 512));
      k++;
    end
  endtask

  // driver + lcd_show_char model; starts and ends 1 time unit after a rising edge
  task automatic run_op(input logic [15:0] n, input logic [8:0] x0, input logic [8:0] y0,
                        input logic size, input logic blank, input bit noise, input int max_delay);
    int cyc, drive_cyc, wait_left, exp_lat;
    bit seen_first, fin;
    logic [6:0] cur_a;
    logic [8:0] cur_x;
    build_expected(n, x0, size, blank);
    if (noise) begin
      repeat (3) begin
        show_char_done = 1'b1;
        @(posedge sys_clk); #1;
        show_char_done = 1'b0;
        @(posedge sys_clk); #1;
      end
    end
    num_in = n; start_x = x0; start_y = y0; en_size_in = size; blank_lead = blank;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    cyc = 0; drive_cyc = 0; wait_left = 0; seen_first = 1'b0; fin = 1'b0;
    cur_a = '0; cur_x = '0;
    while (!fin && cyc < 600) begin
      @(posedge sys_clk); #1;
      cyc++;
      show_char_done = 1'b0;
      start = 1'b0;
      if (show_char_flag) begin
        exp_lat = seen_first ? drive_cyc + 3 : 18;
        vectors++;
        if (cyc !== exp_lat) begin
          miscompares++;
          $display("FAIL flag_latency: flag at cycle %0d, required %0d", cyc, exp_lat);
        end
        seen_first = 1'b1;
        vectors++;
        if (exp_ascii_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_flag: flag with ascii %0d, required no request", ascii_num);
        end else begin
          cur_a = exp_ascii_q.pop_front();
          cur_x = exp_x_q.pop_front();
          if (ascii_num !== cur_a || char_x !== cur_x) begin
            miscompares++;
            $display("FAIL glyph: ascii %0d x %0d, required ascii %0d x %0d",
                     ascii_num, char_x, cur_a, cur_x);
          end
          vectors++;
          if (char_y !== y0 || en_size !== size || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL y_size_busy: y %0d size %0b busy %0b, required y %0d size %0b busy 1",
                     char_y, en_size, busy, y0, size);
          end
        end
        wait_left = $urandom_range(max_delay, 1);
      end else if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) begin
          vectors++;
          if (ascii_num !== cur_a || char_x !== cur_x) begin
            miscompares++;
            $display("FAIL hold: ascii %0d x %0d changed, required ascii %0d x %0d",
                     ascii_num, char_x, cur_a, cur_x);
          end
          show_char_done = 1'b1;
          drive_cyc = cyc;
        end
      end
      if (done) begin
        vectors++;
        if (cyc !== drive_cyc + 2 || exp_ascii_q.size() != 0) begin
          miscompares++;
          $display("FAIL done: done at cycle %0d with %0d chars left, required cycle %0d with 0",
                   cyc, exp_ascii_q.size(), drive_cyc + 2);
        end
        fin = 1'b1;
      end
      if (noise && !fin) begin
        if (cyc < 14 && $urandom_range(1, 0) == 1) show_char_done = 1'b1;
        if ($urandom_range(3, 0) == 0) begin
          start = 1'b1;
          num_in = 16'($urandom);
          start_x = 9'($urandom);
        end
      end
    end
    if (!fin) begin
      miscompares++;
      $display("FAIL timeout: no done within %0d cycles, required done", cyc);
    end
    show_char_done = 1'b0;
    start = noise;
    @(posedge sys_clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL after_fin: busy %0b done %0b, required 0 0", busy, done);
    end
    if (noise) begin
      @(posedge sys_clk); #1;
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL fin_start: busy %0b after start in FIN, required 0", busy);
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    start = 1'b0; num_in = '0; start_x = '0; start_y = '0;
    en_size_in = 1'b0; blank_lead = 1'b0; show_char_done = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    vectors++;
    if ({show_char_flag, ascii_num, char_x, char_y, en_size, busy, done} !== '0 ||
        fsm_state !== S_IDLE) begin
      miscompares++;
      $display("FAIL reset_outputs: flag %0b ascii %0d x %0d y %0d busy %0b done %0b, required all 0",
               show_char_flag, ascii_num, char_x, char_y, busy, done);
    end
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_basic();
    run_op(16'd12345, 9'd10, 9'd20, 1'b0, 1'b0, 1'b0, 4);
  endtask

  task automatic test_blank_lead();
    run_op(16'd42, 9'd0, 9'd33, 1'b1, 1'b1, 1'b0, 3);
    run_op(16'd0, 9'd40, 9'd7, 1'b0, 1'b1, 1'b0, 2);
  endtask

  task automatic test_x_wrap();
    run_op(16'($urandom), 9'd500, 9'd100, 1'b1, 1'b0, 1'b0, 3);
  endtask

  task automatic test_ignore();
    run_op(16'($urandom), 9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 1'b1, 5);
  endtask

  task automatic test_reset_mid();
    int cyc;
    num_in = 16'd9876; start_x = 9'd3; start_y = 9'd4; en_size_in = 1'b1; blank_lead = 1'b0;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!show_char_flag && cyc < 100) begin
      @(posedge sys_clk); #1;
      cyc++;
    end
    vectors++;
    if (!show_char_flag) begin
      miscompares++;
      $display("FAIL abort_setup: no flag within %0d cycles, required a flag", cyc);
    end
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      vectors++;
      if ({show_char_flag, ascii_num, char_x, char_y, en_size, busy, done} !== '0) begin
        miscompares++;
        $display("FAIL abort_outputs: flag %0b ascii %0d x %0d busy %0b done %0b, required all 0",
                 show_char_flag, ascii_num, char_x, busy, done);
      end
    end
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    run_op(16'd305, 9'd60, 9'd61, 1'b0, 1'b1, 1'b0, 3);
  endtask

  task automatic test_back_to_back();
    logic [15:0] corner[3];
    corner[0] = 16'hFFFF;
    corner[1] = 16'd10000;
    corner[2] = 16'd9;
    for (int i = 0; i < 3; i++)
      run_op(corner[i], 9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 1'b0, 4);
    for (int i = 0; i < 10; i++)
      run_op(16'($urandom), 9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 1'b0, 6);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_blank_lead();
    test_x_wrap();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
